// File: rtl/ir_pkg.sv
// Shared NEC timing constants, FSM state type and per-state unit durations for ir_encode.
// The repeat-code states exist only when IR_REPEAT_EN is defined.
package ir_pkg;

    localparam int FRAME_BITS   = 32;
    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int ONE_SPACE_U  = 3;
    localparam int REP_SPACE_U  = 4;
    localparam int SLOT_U       = 192;

    typedef enum logic [3:0] {
        IDLE,
        LEAD_MARK,
        LEAD_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK,
`ifdef IR_REPEAT_EN
        REP_MARK,
        REP_SPACE,
        REP_STOP,
`endif
        GAP
    } ir_state_t;

    // Number of NEC units a state lasts; GAP is ended by the slot counter instead.
    function automatic logic [4:0] state_units(input ir_state_t s, input logic cur_bit);
        logic [4:0] n;
        n = 5'd1;
        case (s)
            LEAD_MARK:  n = 5'(LEAD_MARK_U);
            LEAD_SPACE: n = 5'(LEAD_SPACE_U);
            BIT_SPACE:  n = cur_bit ? 5'(ONE_SPACE_U) : 5'd1;
`ifdef IR_REPEAT_EN
            REP_MARK:   n = 5'(LEAD_MARK_U);
            REP_SPACE:  n = 5'(REP_SPACE_U);
`endif
            default:    n = 5'd1;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ir_encode_if.sv
// Frame handshake between a frame source (master) and the ir_encode transmitter (slave).
// tx_hold is present only when IR_REPEAT_EN is defined.
interface ir_encode_if;

    logic [31:0] tx_data;
    logic        tx_vld;
    logic        tx_rdy;
    logic        tx_done;
`ifdef IR_REPEAT_EN
    logic        tx_hold;
`endif

    modport master (
`ifdef IR_REPEAT_EN
        output tx_hold,
`endif
        output tx_data,
        output tx_vld,
        input  tx_rdy,
        input  tx_done
    );

    modport slave (
`ifdef IR_REPEAT_EN
        input  tx_hold,
`endif
        input  tx_data,
        input  tx_vld,
        output tx_rdy,
        output tx_done
    );

endinterface

// File: rtl/ir_carrier_gen.sv
// Carrier phase counter for the IR LED; clear restarts the phase so every mark begins high.
// carrier_hi is the carrier level of the following cycle, letting the caller register ir_dout against it.
module ir_carrier_gen #(
    parameter int CARR_PERIOD = 1315,
    parameter int CARR_HIGH   = 438
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic carrier_hi
);

    localparam int CW = $clog2(CARR_PERIOD);
    localparam logic [CW-1:0] CARR_LAST = CW'(CARR_PERIOD - 1);
    localparam logic [CW-1:0] HIGH_CNT  = CW'(CARR_HIGH);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt + 1'b1;
        if (clear || cnt == CARR_LAST) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    assign carrier_hi = (cnt_nxt < HIGH_CNT);

endmodule

// File: rtl/ir_encode.sv
// NEC infrared transmitter: leader, 32 LSB-first pulse-distance bits and a stop mark inside a fixed 192-unit slot.
// Define IR_REPEAT_EN to add tx_hold and NEC repeat codes; the default build always returns to IDLE after GAP.
module ir_encode #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int CARRIER_HZ  = 38_000,
    parameter int UNIT_CLKS   = CLK_FREQ / 1000 * 9 / 16,
    parameter int CARR_PERIOD = CLK_FREQ / CARRIER_HZ,
    parameter int CARR_HIGH   = CARR_PERIOD / 3
) (
    input  logic       clk,
    input  logic       rst_n,
    ir_encode_if.slave tx,
    output logic       ir_env,
    output logic       ir_dout
);

    import ir_pkg::*;

    localparam int UW = $clog2(UNIT_CLKS);
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CLKS - 1);
    localparam logic [UW-1:0] UNIT_PEN  = UW'(UNIT_CLKS - 2);
    localparam logic [7:0]    SLOT_LAST = 8'(SLOT_U - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(FRAME_BITS - 1);

    ir_state_t             state;
    logic [UW-1:0]         unit_cnt;
    logic [7:0]            slot_cnt;
    logic [4:0]            state_u;
    logic [4:0]            bit_idx;
    logic [FRAME_BITS-1:0] shreg;
    logic                  rdy_q;
    logic                  done_q;
    logic                  gap_last;
    logic                  unit_tick;
    logic                  state_end;
    logic                  gap_pen;
    logic                  in_space;
    logic                  rep_entry;
    logic                  mark_entry;
    logic                  carrier_hi;
`ifdef IR_REPEAT_EN
    logic                  rep_req;
`endif

    assign unit_tick = (unit_cnt == UNIT_LAST);
    assign state_end = unit_tick && (state_u == state_units(state, shreg[0]) - 5'd1);
    // Second-to-last cycle of the slot: tx_done and the repeat decision are registered from here.
    assign gap_pen   = (state == GAP) && (slot_cnt == SLOT_LAST) && (unit_cnt == UNIT_PEN);

`ifdef IR_REPEAT_EN
    assign in_space  = (state == LEAD_SPACE) || (state == BIT_SPACE) || (state == REP_SPACE);
    assign rep_entry = (state == GAP) && gap_last && rep_req;
`else
    assign in_space  = (state == LEAD_SPACE) || (state == BIT_SPACE);
    assign rep_entry = 1'b0;
`endif
    assign mark_entry = ((state == IDLE) && tx.tx_vld) || (in_space && state_end) || rep_entry;

    assign tx.tx_rdy  = rdy_q;
    assign tx.tx_done = done_q;

    ir_carrier_gen #(
        .CARR_PERIOD(CARR_PERIOD),
        .CARR_HIGH  (CARR_HIGH)
    ) carrier (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (mark_entry),
        .carrier_hi(carrier_hi)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            unit_cnt <= '0;
            slot_cnt <= '0;
            state_u  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rdy_q    <= 1'b1;
            done_q   <= 1'b0;
            gap_last <= 1'b0;
            ir_env   <= 1'b0;
            ir_dout  <= 1'b0;
`ifdef IR_REPEAT_EN
            rep_req  <= 1'b0;
`endif
        end else begin
            ir_dout  <= ir_env && carrier_hi;
            gap_last <= gap_pen;
`ifdef IR_REPEAT_EN
            done_q   <= gap_pen && !tx.tx_hold;
            rep_req  <= gap_pen && tx.tx_hold;
`else
            done_q   <= gap_pen;
`endif

            if (state != IDLE) begin
                unit_cnt <= unit_tick ? '0 : unit_cnt + 1'b1;
                if (unit_tick) begin
                    slot_cnt <= slot_cnt + 1'b1;
                    state_u  <= state_end ? '0 : state_u + 1'b1;
                end
            end

            // Mark entries force ir_dout high because the carrier phase restarts at its high portion.
            case (state)
                IDLE: begin
                    unit_cnt <= '0;
                    slot_cnt <= '0;
                    state_u  <= '0;
                    if (tx.tx_vld) begin
                        state   <= LEAD_MARK;
                        shreg   <= tx.tx_data;
                        bit_idx <= '0;
                        rdy_q   <= 1'b0;
                        ir_env  <= 1'b1;
                        ir_dout <= 1'b1;
                    end
                end
                LEAD_MARK: if (state_end) begin
                    state   <= LEAD_SPACE;
                    ir_env  <= 1'b0;
                    ir_dout <= 1'b0;
                end
                LEAD_SPACE: if (state_end) begin
                    state   <= BIT_MARK;
                    ir_env  <= 1'b1;
                    ir_dout <= 1'b1;
                end
                BIT_MARK: if (state_end) begin
                    state   <= BIT_SPACE;
                    ir_env  <= 1'b0;
                    ir_dout <= 1'b0;
                end
                BIT_SPACE: if (state_end) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 1'b1;
                    state   <= (bit_idx == BIT_LAST) ? STOP_MARK : BIT_MARK;
                    ir_env  <= 1'b1;
                    ir_dout <= 1'b1;
                end
                STOP_MARK: if (state_end) begin
                    state   <= GAP;
                    ir_env  <= 1'b0;
                    ir_dout <= 1'b0;
                end
`ifdef IR_REPEAT_EN
                REP_MARK: if (state_end) begin
                    state   <= REP_SPACE;
                    ir_env  <= 1'b0;
                    ir_dout <= 1'b0;
                end
                REP_SPACE: if (state_end) begin
                    state   <= REP_STOP;
                    ir_env  <= 1'b1;
                    ir_dout <= 1'b1;
                end
                REP_STOP: if (state_end) begin
                    state   <= GAP;
                    ir_env  <= 1'b0;
                    ir_dout <= 1'b0;
                end
`endif
                GAP: if (gap_last) begin
`ifdef IR_REPEAT_EN
                    if (rep_req) begin
                        state    <= REP_MARK;
                        unit_cnt <= '0;
                        slot_cnt <= '0;
                        ir_env   <= 1'b1;
                        ir_dout  <= 1'b1;
                    end else
`endif
                    begin
                        state <= IDLE;
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_encode.sv
// Randomised bench for ir_encode with shortened NEC units, checked against a mark/space run-length model of the frame.
// Build with IR_REPEAT_EN defined to also exercise the repeat-code path.
module tb_ir_encode;

    localparam int U    = 16;
    localparam int P    = 7;
    localparam int H    = 2;
    localparam int SLOT = 192 * U;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ir_env;
    logic ir_dout;

    int tests = 0;
    int fails = 0;

    int exp_seg[$];
    bit exp_env[$];
    bit exp_dout[$];

    ir_encode_if tx_if ();

    ir_encode #(
        .UNIT_CLKS  (U),
        .CARR_PERIOD(P),
        .CARR_HIGH  (H)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx     (tx_if),
        .ir_env (ir_env),
        .ir_dout(ir_dout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Expected envelope as alternating run lengths (mark first), then expanded per cycle with the carrier.
    task automatic buildModel(input logic [31:0] data, input int reps);
        int used;
        exp_seg = {};
        exp_env = {};
        exp_dout = {};
        exp_seg.push_back(16 * U);
        exp_seg.push_back(8 * U);
        used = 24 * U;
        for (int i = 0; i < 32; i++) begin
            exp_seg.push_back(U);
            exp_seg.push_back(data[i] ? 3 * U : U);
            used += data[i] ? 4 * U : 2 * U;
        end
        exp_seg.push_back(U);
        used += U;
        exp_seg.push_back(SLOT - used);
        for (int r = 0; r < reps; r++) begin
            exp_seg.push_back(16 * U);
            exp_seg.push_back(4 * U);
            exp_seg.push_back(U);
            exp_seg.push_back(SLOT - 21 * U);
        end
        foreach (exp_seg[s]) begin
            for (int j = 0; j < exp_seg[s]; j++) begin
                exp_env.push_back(s % 2 == 0);
                exp_dout.push_back((s % 2 == 0) && (j % P < H));
            end
        end
    endtask

    task automatic applyStimulus(input logic [31:0] data);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!tx_if.tx_rdy && waited < 2 * SLOT) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rdy_before_send", tx_if.tx_rdy, 1);
        tx_if.tx_data = data;
        tx_if.tx_vld  = 1'b1;
        @(posedge clk);
    endtask

    // Called right after the accepting edge; k counts cycles from acceptance.
    task automatic observeFrame(input logic [31:0] data, input int reps, input bit chain,
                                input logic [31:0] next_data);
        int k_end, done_at, done_cnt, rdy_at, env_err, dout_err, run;
        int runs[$];
        logic prev, first_env;
        logic [31:0] decoded;
        buildModel(data, reps);
        k_end = SLOT * (1 + reps);
        done_at = -1;
        done_cnt = 0;
        rdy_at = -1;
        env_err = 0;
        dout_err = 0;
        run = 0;
        prev = 1'b0;
        first_env = 1'b0;
        for (int k = 1; k <= k_end + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                first_env = ir_env;
                if (chain) tx_if.tx_data = next_data;
                else tx_if.tx_vld = 1'b0;
            end
`ifdef IR_REPEAT_EN
            tx_if.tx_hold = (reps > 0) && (k < SLOT * reps + SLOT / 2);
`endif
            if (tx_if.tx_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (tx_if.tx_rdy && rdy_at < 0) rdy_at = k;
            if (k <= k_end) begin
                if (ir_env !== exp_env[k-1]) env_err++;
                if (ir_dout !== exp_dout[k-1]) dout_err++;
                if (k > 1 && ir_env !== prev) begin
                    runs.push_back(run);
                    run = 0;
                end
                run++;
                prev = ir_env;
            end else begin
                runs.push_back(run);
                checkOutput("env_after_slot", ir_env, 0);
            end
        end
        checkOutput("env_first_cycle", first_env, 1);
        checkOutput("seg_count", runs.size(), exp_seg.size());
        for (int s = 0; s < runs.size() && s < exp_seg.size(); s++) begin
            checkOutput($sformatf("seg%0d", s), runs[s], exp_seg[s]);
        end
        decoded = '0;
        for (int b = 0; b < 32; b++) begin
            if (3 + 2 * b < runs.size()) decoded[b] = (runs[3 + 2 * b] > 2 * U);
        end
        checkOutput("decoded_frame", decoded, data);
        checkOutput("env_cycles_wrong", env_err, 0);
        checkOutput("dout_cycles_wrong", dout_err, 0);
        checkOutput("done_cycle", done_at, k_end);
        checkOutput("done_count", done_cnt, 1);
        checkOutput("rdy_cycle", rdy_at, k_end + 1);
    endtask

    initial begin
        logic [31:0] d;
        int bad, kr, done_cnt, env_hi, reps;
        tx_if.tx_data = '0;
        tx_if.tx_vld  = 1'b0;
`ifdef IR_REPEAT_EN
        tx_if.tx_hold = 1'b0;
`endif
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_rdy", tx_if.tx_rdy, 1);
        checkOutput("reset_env", ir_env, 0);
        checkOutput("reset_dout", ir_dout, 0);
        checkOutput("reset_done", tx_if.tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_if.tx_rdy !== 1'b1 || ir_env !== 1'b0 || ir_dout !== 1'b0 || tx_if.tx_done !== 1'b0) bad++;
        end
        checkOutput("idle_bad_cycles", bad, 0);

        applyStimulus(32'h00FF_00FF);
        observeFrame(32'h00FF_00FF, 0, 1'b0, 32'h0);
        applyStimulus(32'h12ED_40BF);
        observeFrame(32'h12ED_40BF, 0, 1'b0, 32'h0);

        // Back-to-back: tx_vld stays high with different data while busy.
        d = $urandom;
        applyStimulus(32'hA5A5_0F0F);
        observeFrame(32'hA5A5_0F0F, 0, 1'b1, d);
        observeFrame(d, 0, 1'b0, 32'h0);

        for (int n = 0; n < 3; n++) begin
            d = $urandom;
            reps = 0;
`ifdef IR_REPEAT_EN
            reps = $urandom_range(0, 1);
`endif
            applyStimulus(d);
            observeFrame(d, reps, 1'b0, 32'h0);
        end

`ifdef IR_REPEAT_EN
        d = $urandom;
        applyStimulus(d);
        observeFrame(d, 2, 1'b0, 32'h0);
`endif

        // Reset in the middle of the bit-10 mark.
        d = $urandom;
        applyStimulus(d);
        kr = 24 * U;
        for (int i = 0; i < 10; i++) kr += d[i] ? 4 * U : 2 * U;
        kr += U / 2;
        for (int k = 1; k <= kr; k++) begin
            @(negedge clk);
            if (k == 1) tx_if.tx_vld = 1'b0;
        end
        checkOutput("env_before_reset", ir_env, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midrst_env", ir_env, 0);
        checkOutput("midrst_dout", ir_dout, 0);
        checkOutput("midrst_rdy", tx_if.tx_rdy, 1);
        checkOutput("midrst_done", tx_if.tx_done, 0);
        done_cnt = 0;
        env_hi = 0;
        repeat (SLOT) begin
            @(negedge clk);
            if (tx_if.tx_done) done_cnt++;
            if (ir_env) env_hi++;
        end
        checkOutput("no_done_after_reset", done_cnt, 0);
        checkOutput("env_idle_after_reset", env_hi, 0);
        d = $urandom;
        applyStimulus(d);
        observeFrame(d, 0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
